// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encoding and byte-lane helpers for the data memory
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dmem_size_e;

    // Helpers work on an 8-lane (64-bit) view; narrower memories use the low lanes.
    function automatic logic [7:0] lane_mask(input dmem_size_e size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] word, input logic [2:0] offset,
                                           input dmem_size_e size, input logic uns);
        logic [63:0] sh;
        sh = word >> {offset, 3'b000};
        case (size)
            SZ_B:    return uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    return uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    return uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bl_if.sv
// rtl/data_memory_bl_if.sv - request/response channel between LSU and data memory
interface data_memory_bl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_uns;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - moves store data into byte lanes and extracts/extends load data
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  dmem_size_e                     size_i,
    input  logic [$clog2(DATA_W/8)-1:0]    offset_i,
    input  logic                           uns_i,
    input  logic [DATA_W-1:0]              wdata_i,
    input  logic [DATA_W-1:0]              rword_i,
    output logic [DATA_W-1:0]              wdata_o,
    output logic [DATA_W/8-1:0]            wstrb_o,
    output logic [DATA_W-1:0]              rdata_o
);
    localparam int LANES = DATA_W / 8;

    logic [2:0]  off3;
    logic [7:0]  mask8;
    logic [63:0] w64;
    logic [63:0] r64;
    logic        unused_hi;

    always_comb begin
        off3  = 3'(offset_i);
        mask8 = lane_mask(size_i, off3);
        w64   = 64'(wdata_i) << {off3, 3'b000};
        r64   = extend(64'(rword_i), off3, size_i, uns_i);
    end

    assign wdata_o   = w64[DATA_W-1:0];
    assign wstrb_o   = mask8[LANES-1:0];
    assign rdata_o   = r64[DATA_W-1:0];
    // Upper lanes are only meaningful for a 64-bit memory.
    assign unused_hi = ^{w64, r64, mask8};

endmodule

// File: rtl/data_memory_bl.sv
// rtl/data_memory_bl.sv - byte-addressable data memory with faulting, extension and a one-entry response register
module data_memory_bl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    data_memory_bl_if.slave          bus,
    input  logic [$clog2(DEPTH)-1:0] probe_addr,
    output logic [DATA_W-1:0]        probe_data
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    dmem_size_e        size;
    logic [OFF_W-1:0]  offset;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        align_mask;
    logic              out_of_range;
    logic              misaligned;
    logic              bad_size;
    logic              fault;
    logic              accept;

    logic [DATA_W-1:0] wdata_al;
    logic [LANES-1:0]  wstrb;
    logic [DATA_W-1:0] rdata_ext;

    always_comb begin
        size         = dmem_size_e'(bus.req_size);
        offset       = bus.req_addr[OFF_W-1:0];
        idx          = bus.req_addr[OFF_W+IDX_W-1:OFF_W];
        out_of_range = |(bus.req_addr >> (OFF_W + IDX_W));
        case (size)
            SZ_B:    align_mask = 3'd0;
            SZ_H:    align_mask = 3'd1;
            SZ_W:    align_mask = 3'd3;
            default: align_mask = 3'd7;
        endcase
        misaligned   = (3'(offset) & align_mask) != 3'd0;
        bad_size     = (size == SZ_D) && (DATA_W == 32);
        fault        = out_of_range | misaligned | bad_size;
    end

    // Single-entry response slot: a pop frees it for a request in the same cycle.
    assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i   (size),
        .offset_i (offset),
        .uns_i    (bus.req_uns),
        .wdata_i  (bus.req_wdata),
        .rword_i  (mem_q[idx]),
        .wdata_o  (wdata_al),
        .wstrb_o  (wstrb),
        .rdata_o  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else if (accept && bus.req_we && !fault) begin
            for (int l = 0; l < LANES; l++) begin
                if (wstrb[l]) begin
                    mem_q[idx][l*8 +: 8] <= wdata_al[l*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = fault;
            rsp_rdata_d = (bus.req_we || fault) ? '0 : rdata_ext;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign probe_data    = mem_q[probe_addr];

endmodule

// File: tb/tb_data_memory_bl.sv
// tb/tb_data_memory_bl.sv - directed and randomized checks of data_memory_bl against a byte-array model
module tb_data_memory_bl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [IDX_W-1:0]  probe_addr;
    logic [DATA_W-1:0] probe_data;

    data_memory_bl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_memory_bl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .probe_addr (probe_addr),
        .probe_data (probe_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: memory as a flat little-endian byte array, response as a single slot.
    logic [7:0]  mb [DEPTH*4];
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        m_fault;

    function automatic logic [31:0] mword(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    function automatic bit mfault(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = 1 << sz;
        return (sz == 2'd3) || ((a % n) != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] mload(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        longint v;
        int     n;
        n = 1 << sz;
        v = 0;
        for (int k = 0; k < n; k++) v = v | (longint'(mb[a + k]) << (8 * k));
        if (!uns && v[8*n-1]) v = v | -(longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH * 4; i++) mb[i] <= 8'((i / 4) >> (8 * (i % 4)));
            m_valid <= 1'b0;
            m_rdata <= '0;
            m_fault <= 1'b0;
        end else if (bus.req_valid && (!m_valid || bus.rsp_ready)) begin
            m_valid <= 1'b1;
            m_fault <= mfault(bus.req_size, bus.req_addr);
            m_rdata <= (bus.req_we || mfault(bus.req_size, bus.req_addr)) ? 32'd0
                       : mload(bus.req_size, bus.req_uns, bus.req_addr);
            if (bus.req_we && !mfault(bus.req_size, bus.req_addr)) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < (1 << bus.req_size)) mb[bus.req_addr + k] <= bus.req_wdata[8*k +: 8];
                end
            end
        end else if (bus.rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("req_ready", bus.req_ready, !m_valid || bus.rsp_ready);
            check("rsp_valid", bus.rsp_valid, m_valid);
            if (m_valid) begin
                check("rsp_rdata", bus.rsp_rdata, m_rdata);
                check("rsp_fault", bus.rsp_fault, m_fault);
            end
            check("probe_data", probe_data, mword(int'(probe_addr)));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        bit acc;
        int n;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_uns   = uns;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("accept", acc, 1'b1);
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] rd, input logic flt);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, bus.rsp_valid, 1'b1);
        check({name, "_rdata"}, bus.rsp_rdata, rd);
        check({name, "_fault"}, bus.rsp_fault, flt);
        check({name, "_model"}, m_rdata, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_uns   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        probe_addr    = IDX_W'(4);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        check("reset_valid", bus.rsp_valid, 1'b0);
        check("reset_rdata", bus.rsp_rdata, 32'd0);
        check("reset_fault", bus.rsp_fault, 1'b0);
        check("reset_probe4", probe_data, 32'd4);
        @(posedge clk);
        #1;

        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        expect_rsp("ld_w10", 32'h0000_0004, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h09, 32'h80);
        expect_rsp("st_b09", 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h09, 32'h0);
        expect_rsp("ld_b09_s", 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h09, 32'h0);
        expect_rsp("ld_b09_u", 32'h0000_0080, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        expect_rsp("ld_w08", 32'h0000_8002, 1'b0);

        probe_addr = '0;
        issue(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFF);
        expect_rsp("st_h03", 32'h0, 1'b1);
        @(negedge clk);
        check("word0_untouched", probe_data, 32'h0);
        @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 1'b0, 32'(DEPTH * 4), 32'h0);
        expect_rsp("ld_oor", 32'h0, 1'b1);

        bus.rsp_ready = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_uns   = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_addr = 32'h14;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready", bus.req_ready, 1'b0);
            check("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'h4);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("b2b_0", bus.rsp_rdata, 32'h4);
        @(posedge clk);
        #1 bus.req_addr = 32'h18;
        @(negedge clk);
        check("b2b_1", bus.rsp_rdata, 32'h5);
        @(posedge clk);
        #1 bus.req_addr = 32'h1C;
        @(negedge clk);
        check("b2b_2", bus.rsp_rdata, 32'h6);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_3", bus.rsp_rdata, 32'h7);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_idle", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1;

        probe_addr = IDX_W'(8);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        expect_rsp("ld_20", 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("probe8_store", probe_data, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        bus.rsp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("pre_rst_valid", bus.rsp_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", bus.rsp_valid, 1'b0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_probe8", probe_data, 32'h8);
        @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        expect_rsp("rst_ld20", 32'h8, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            int          sz;
            logic [31:0] a;
            sz = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = $urandom_range(0, DEPTH * 4 + 7);
            if ($urandom_range(0, 2) != 0) a = a & ~(32'(1 << sz) - 32'd1);
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.req_we    = $urandom_range(0, 1);
            bus.req_size  = 2'(sz);
            bus.req_uns   = $urandom_range(0, 1);
            bus.req_addr  = a;
            bus.req_wdata = $urandom();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            probe_addr    = IDX_W'($urandom_range(0, DEPTH - 1));
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
